// File: rtl/ab_bus_arbiter.sv
// Bus arbiter between the core's address generator and one DMA master.
// Ownership changes pass through an idle turnaround cycle, and DMA bursts are length-limited.
//
// state  | meaning
// -------+-----------------------------------------------------------
// CPU    | core owns the bus, DMA requests honoured unless cpu_lock
// TURN_D | idle turnaround towards DMA, core stalled
// DMA    | DMA owns the bus, one transfer per cycle, core stalled
// TURN_C | idle turnaround back to the core, core stalled
// COOL   | core owns the bus for CPU_SLOTS cycles after a forced handback
module ab_bus_arbiter #(
  parameter int MAX_BURST = 16,
  parameter int CPU_SLOTS = 1
) (
  input  logic        clk,
  input  logic        RST,
  input  logic        ABWDTH,
  input  logic [23:0] cpu_ab,
  input  logic        cpu_we,
  input  logic [7:0]  cpu_do,
  input  logic        cpu_lock,
  output logic        cpu_rdy,
  input  logic        dma_req,
  input  logic [23:0] dma_ab,
  input  logic        dma_we,
  input  logic [7:0]  dma_do,
  output logic        dma_gnt,
  output logic [23:0] AB,
  output logic        WE,
  output logic [7:0]  DO,
  output logic        owner
);

  localparam int CW  = $clog2(MAX_BURST + 1);
  localparam int CCW = $clog2(CPU_SLOTS + 1);
  localparam logic [CW-1:0]  CNT_LAST  = CW'(MAX_BURST - 1);
  localparam logic [CCW-1:0] CCNT_LAST = CCW'(CPU_SLOTS - 1);

  typedef enum logic [2:0] {
    S_CPU,
    S_TURN_D,
    S_DMA,
    S_TURN_C,
    S_COOL
  } state_t;

  state_t         state, state_nxt;
  logic [CW-1:0]  cnt, cnt_nxt;
  logic [CCW-1:0] ccnt, ccnt_nxt;
  logic           lim, lim_nxt;
  logic [23:0]    cpu_ab_m;

  always_ff @(posedge clk) begin
    if (RST) begin
      state <= S_CPU;
      cnt   <= '0;
      ccnt  <= '0;
      lim   <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      ccnt  <= ccnt_nxt;
      lim   <= lim_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    ccnt_nxt  = ccnt;
    lim_nxt   = lim;
    case (state)
      S_CPU: begin
        if (dma_req && !cpu_lock) state_nxt = S_TURN_D;
      end
      S_TURN_D: begin
        cnt_nxt   = '0;
        state_nxt = dma_req ? S_DMA : S_CPU;
      end
      S_DMA: begin
        cnt_nxt = cnt + 1'b1;
        // lim remembers whether the burst was cut short, selecting COOL after TURN_C
        if (!dma_req || (cnt == CNT_LAST)) begin
          state_nxt = S_TURN_C;
          lim_nxt   = (cnt == CNT_LAST);
        end
      end
      S_TURN_C: begin
        ccnt_nxt  = '0;
        state_nxt = lim ? S_COOL : S_CPU;
      end
      S_COOL: begin
        if (ccnt == CCNT_LAST) state_nxt = S_CPU;
        else                   ccnt_nxt  = ccnt + 1'b1;
      end
      default: state_nxt = S_CPU;
    endcase
  end

  assign cpu_ab_m = ABWDTH ? cpu_ab : {8'h00, cpu_ab[15:0]};

  // Reset overrides the decode immediately so a burst aborts on the RST cycle itself
  always_comb begin
    AB      = cpu_ab_m;
    WE      = 1'b0;
    DO      = cpu_do;
    cpu_rdy = 1'b0;
    dma_gnt = 1'b0;
    owner   = 1'b0;
    if (RST) begin
      cpu_rdy = 1'b1;
    end else begin
      case (state)
        S_CPU, S_COOL: begin
          cpu_rdy = 1'b1;
          WE      = cpu_we;
        end
        S_DMA: begin
          AB      = dma_ab;
          WE      = dma_we;
          DO      = dma_do;
          dma_gnt = 1'b1;
          owner   = 1'b1;
        end
        default: begin
          cpu_rdy = 1'b0;
        end
      endcase
    end
  end

endmodule
